// File: rtl/bus_mem_pkg.sv
// Shared types and defaults for the processor8bit program/data memory and its loader.
// Pure declarations: no logic, no latency, no flow control.
// Holds the loader FSM state encoding used by the top level.
package bus_mem_pkg;
    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 8;
    localparam int REL_DLY_DEF = 2;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        REL  = 2'd2,
        RUN  = 2'd3
    } state_t;
endpackage

// File: rtl/bus_mem_loader_if.sv
// CPU strobe/address bus and loader byte stream bundled between the CPU side and the memory.
// Wires only, zero latency; ld_ready is the single backpressure signal of the stream.
// The master drives add/rd/wrt and the stream; the slave (memory) returns ld_ready.
interface bus_mem_loader_if
    import bus_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();
    logic [AW-1:0] add;
    logic          rd;
    logic          wrt;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_last;

    modport master (
        output add, rd, wrt, ld_start, ld_valid, ld_data, ld_last,
        input  ld_ready
    );

    modport slave (
        input  add, rd, wrt, ld_start, ld_valid, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/bus_mem_ram.sv
// 2**AW x DW storage with an asynchronous read port and one synchronous write port.
// Read: same cycle; write: lands on the next posedge. No backpressure.
// Contents are deliberately not reset so an image survives a reset pulse.
module bus_mem_ram
    import bus_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bus_mem_loader.sv
// Program/data memory on the processor8bit bus with a valid/ready image loader (option: BUS_MEM_WPROT_EN).
// CPU reads are combinational, writes land at posedge; cpu_rst drops REL_DLY cycles after the last byte.
// ld_ready is high only while loading; CPU strobes are ignored while cpu_rst is high.
module bus_mem_loader
    import bus_mem_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int REL_DLY = REL_DLY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    bus_mem_loader_if.slave     bus,
    inout  wire  [DW-1:0]       dat,
    output logic                cpu_rst,
    output logic [AW:0]         ld_count,
    output logic                bus_err
`ifdef BUS_MEM_WPROT_EN
    ,
    output logic                wp_viol
`endif
);
    localparam int RCW = (REL_DLY > 1) ? $clog2(REL_DLY) : 1;
    localparam logic [RCW-1:0] REL_LAST = RCW'(REL_DLY - 1);

    state_t         state;
    logic [AW-1:0]  ptr;
    logic [RCW-1:0] rel_cnt;
    logic           ld_ready_q;

    logic           ld_hs;
    logic           ld_final;
    logic           cpu_rd;
    logic           cpu_wr_req;
    logic           wp_block;
    logic           cpu_we;

    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [DW-1:0]  ram_wdata;
    logic [DW-1:0]  ram_rdata;

    assign bus.ld_ready = ld_ready_q;

    assign ld_hs      = (state == LOAD) && bus.ld_valid && ld_ready_q;
    // The top address always ends the image so the pointer never wraps onto address 0.
    assign ld_final   = ld_hs && (bus.ld_last || (&ptr));
    assign cpu_rd     = (state == RUN) && bus.rd && !bus.wrt;
    assign cpu_wr_req = (state == RUN) && bus.wrt && !bus.rd;

`ifdef BUS_MEM_WPROT_EN
    assign wp_block = cpu_wr_req && ({1'b0, bus.add} < ld_count);
`else
    assign wp_block = 1'b0;
`endif
    assign cpu_we = cpu_wr_req && !wp_block;

    assign ram_we    = ld_hs || cpu_we;
    assign ram_waddr = (state == LOAD) ? ptr : bus.add;
    assign ram_wdata = (state == LOAD) ? bus.ld_data : dat;

    assign dat = cpu_rd ? ram_rdata : {DW{1'bz}};

    bus_mem_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (bus.add),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HOLD;
            ptr        <= '0;
            rel_cnt    <= '0;
            ld_ready_q <= 1'b0;
            cpu_rst    <= 1'b1;
            ld_count   <= '0;
            bus_err    <= 1'b0;
`ifdef BUS_MEM_WPROT_EN
            wp_viol    <= 1'b0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (bus.ld_start) begin
                        state      <= LOAD;
                        ld_ready_q <= 1'b1;
                        ptr        <= '0;
                        ld_count   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_hs) begin
                        ptr      <= ptr + 1'b1;
                        ld_count <= {1'b0, ptr} + {{AW{1'b0}}, 1'b1};
                        if (ld_final) begin
                            state      <= REL;
                            ld_ready_q <= 1'b0;
                            rel_cnt    <= '0;
                        end
                    end
                end
                REL: begin
                    if (rel_cnt == REL_LAST) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.ld_start) begin
                        state      <= LOAD;
                        cpu_rst    <= 1'b1;
                        ld_ready_q <= 1'b1;
                        ptr        <= '0;
                        ld_count   <= '0;
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase

            if ((state == RUN) && bus.rd && bus.wrt) begin
                bus_err <= 1'b1;
            end
`ifdef BUS_MEM_WPROT_EN
            if (wp_block) begin
                wp_viol <= 1'b1;
            end
`endif
        end
    end
endmodule
